// File: rtl/mips_pkg.sv
// Shared definitions for the five-stage MIPS core: ALU function codes,
// the zero register number and the ID/EX pipeline register layout.
package mips_pkg;

    localparam logic [5:0] ALU_ADD = 6'b000000;
    localparam logic [5:0] ALU_SUB = 6'b000001;
    localparam logic [5:0] ALU_AND = 6'b011000;
    localparam logic [5:0] ALU_OR  = 6'b011110;
    localparam logic [5:0] ALU_XOR = 6'b010110;
    localparam logic [5:0] ALU_NOR = 6'b010001;
    localparam logic [5:0] ALU_SLL = 6'b100000;
    localparam logic [5:0] ALU_SRL = 6'b100001;
    localparam logic [5:0] ALU_SRA = 6'b100011;
    localparam logic [5:0] ALU_EQ  = 6'b110011;
    localparam logic [5:0] ALU_LT  = 6'b110101;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic        valid;
        logic        wr_en;
        logic        is_load;
        logic [4:0]  wr_addr;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic        alu_src;
        logic        shamt_src;
        logic [5:0]  alufun;
        logic        sign;
    } ex_regs_t;

    // A bubble keeps the datapath fields but can never write or be seen as a load.
    function automatic ex_regs_t make_bubble(input ex_regs_t r);
        ex_regs_t b;
        b         = r;
        b.valid   = 1'b0;
        b.wr_en   = 1'b0;
        b.is_load = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding: EX/MEM result wins over MEM/WB, which wins over the
// register-file value; register 0 always reads its raw value.
module fwd_mux
    import mips_pkg::*;
(
    input  logic [4:0]  reg_num,
    input  logic [31:0] reg_data,
    input  logic        exm_wr_en,
    input  logic [4:0]  exm_wr_addr,
    input  logic [31:0] exm_data,
    input  logic        mwb_wr_en,
    input  logic [4:0]  mwb_wr_addr,
    input  logic [31:0] mwb_data,
    output logic [31:0] fwd_data
);

    always_comb begin
        fwd_data = reg_data;
        if (reg_num != REG_ZERO) begin
            if (exm_wr_en && (exm_wr_addr == reg_num)) begin
                fwd_data = exm_data;
            end else if (mwb_wr_en && (mwb_wr_addr == reg_num)) begin
                fwd_data = mwb_data;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall, flush and load-use bubbles, plus
// forwarded ALU operand selection feeding the combinational ALU.
module id_ex_stage
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_shamt,
    input  logic        id_alu_src,
    input  logic        id_shamt_src,
    input  logic [5:0]  id_alufun,
    input  logic        id_sign,
    input  logic        id_wr_en,
    input  logic [4:0]  id_wr_addr,
    input  logic        id_is_load,
    input  logic        stall,
    input  logic        flush,
    input  logic        exm_wr_en,
    input  logic [4:0]  exm_wr_addr,
    input  logic [31:0] exm_data,
    input  logic        mwb_wr_en,
    input  logic [4:0]  mwb_wr_addr,
    input  logic [31:0] mwb_data,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [5:0]  alu_fun,
    output logic        alu_sign,
    output logic        ex_valid,
    output logic        ex_wr_en,
    output logic        ex_is_load,
    output logic [4:0]  ex_wr_addr,
    output logic [31:0] ex_store_data,
    output logic        hazard
);

    // Flow control: ex_valid marks a real instruction in EX. stall holds the
    // stage (forwarding still live); hazard asks decode to hold while a bubble
    // is inserted; flush squashes whatever would enter EX this edge.
    ex_regs_t    ex_q;
    ex_regs_t    id_d;
    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;

    always_comb begin
        id_d           = '0;
        id_d.valid     = id_valid;
        id_d.wr_en     = id_wr_en;
        id_d.is_load   = id_is_load;
        id_d.wr_addr   = id_wr_addr;
        id_d.rs        = id_rs;
        id_d.rt        = id_rt;
        id_d.rs_data   = id_rs_data;
        id_d.rt_data   = id_rt_data;
        id_d.imm       = id_imm;
        id_d.shamt     = id_shamt;
        id_d.alu_src   = id_alu_src;
        id_d.shamt_src = id_shamt_src;
        id_d.alufun    = id_alufun;
        id_d.sign      = id_sign;
    end

    assign hazard = ex_q.valid && ex_q.is_load && (ex_q.wr_addr != REG_ZERO) &&
                    id_valid && ((id_rs == ex_q.wr_addr) || (id_rt == ex_q.wr_addr));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else if (flush) begin
            ex_q <= make_bubble(id_d);
        end else if (stall) begin
            ex_q <= ex_q;
        end else if (hazard) begin
            ex_q <= make_bubble(id_d);
        end else begin
            ex_q <= id_d;
        end
    end

    fwd_mux u_fwd_rs (
        .reg_num     (ex_q.rs),
        .reg_data    (ex_q.rs_data),
        .exm_wr_en   (exm_wr_en),
        .exm_wr_addr (exm_wr_addr),
        .exm_data    (exm_data),
        .mwb_wr_en   (mwb_wr_en),
        .mwb_wr_addr (mwb_wr_addr),
        .mwb_data    (mwb_data),
        .fwd_data    (fwd_rs)
    );

    fwd_mux u_fwd_rt (
        .reg_num     (ex_q.rt),
        .reg_data    (ex_q.rt_data),
        .exm_wr_en   (exm_wr_en),
        .exm_wr_addr (exm_wr_addr),
        .exm_data    (exm_data),
        .mwb_wr_en   (mwb_wr_en),
        .mwb_wr_addr (mwb_wr_addr),
        .mwb_data    (mwb_data),
        .fwd_data    (fwd_rt)
    );

    assign alu_a         = ex_q.shamt_src ? {27'b0, ex_q.shamt} : fwd_rs;
    assign alu_b         = ex_q.alu_src ? ex_q.imm : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign alu_fun       = ex_q.alufun;
    assign alu_sign      = ex_q.sign;
    assign ex_valid      = ex_q.valid;
    assign ex_wr_en      = ex_q.wr_en;
    assign ex_is_load    = ex_q.is_load;
    assign ex_wr_addr    = ex_q.wr_addr;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, hand-written hazard/stall/
// flush/reset sequences, then randomized traffic against a reference model.
module tb_id_ex_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_shamt, id_wr_addr;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        id_alu_src, id_shamt_src, id_sign, id_wr_en, id_is_load;
    logic [5:0]  id_alufun;
    logic        stall, flush;
    logic        exm_wr_en, mwb_wr_en;
    logic [4:0]  exm_wr_addr, mwb_wr_addr;
    logic [31:0] exm_data, mwb_data;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [5:0]  alu_fun;
    logic        alu_sign, ex_valid, ex_wr_en, ex_is_load, hazard;
    logic [4:0]  ex_wr_addr;

    int c_cnt = 0;
    int f_cnt = 0;
    logic [31:0] exp_q[$];

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_shamt(id_shamt), .id_alu_src(id_alu_src), .id_shamt_src(id_shamt_src),
        .id_alufun(id_alufun), .id_sign(id_sign), .id_wr_en(id_wr_en),
        .id_wr_addr(id_wr_addr), .id_is_load(id_is_load), .stall(stall), .flush(flush),
        .exm_wr_en(exm_wr_en), .exm_wr_addr(exm_wr_addr), .exm_data(exm_data),
        .mwb_wr_en(mwb_wr_en), .mwb_wr_addr(mwb_wr_addr), .mwb_data(mwb_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_sign(alu_sign),
        .ex_valid(ex_valid), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
        .ex_wr_addr(ex_wr_addr), .ex_store_data(ex_store_data), .hazard(hazard)
    );

    // clock / reset
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_rs_data = 0; id_rt_data = 0;
        id_imm = 0; id_shamt = 0; id_alu_src = 0; id_shamt_src = 0;
        id_alufun = 0; id_sign = 0; id_wr_en = 0; id_wr_addr = 0; id_is_load = 0;
        stall = 0; flush = 0;
        exm_wr_en = 0; exm_wr_addr = 0; exm_data = 0;
        mwb_wr_en = 0; mwb_wr_addr = 0; mwb_data = 0;
    endtask

    task automatic drive_fwd(input logic ee, input logic [4:0] ea, input logic [31:0] ed,
                             input logic me, input logic [4:0] ma, input logic [31:0] md);
        exm_wr_en = ee; exm_wr_addr = ea; exm_data = ed;
        mwb_wr_en = me; mwb_wr_addr = ma; mwb_data = md;
    endtask

    task automatic drive_id_random();
        id_valid = 1'($urandom_range(0, 1)); id_rs = 5'($urandom_range(0, 7));
        id_rt = 5'($urandom_range(0, 7)); id_rs_data = $urandom; id_rt_data = $urandom;
        id_imm = $urandom; id_shamt = 5'($urandom); id_alu_src = 1'($urandom);
        id_shamt_src = 1'($urandom); id_alufun = 6'($urandom); id_sign = 1'($urandom);
        id_wr_en = 1'($urandom); id_wr_addr = 5'($urandom_range(0, 7));
        id_is_load = ($urandom_range(0, 2) == 0);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        c_cnt++;
        if (act !== exp) begin
            f_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic        valid, wr_en, is_load, known;
        logic [4:0]  wr_addr, rs, rt, shamt;
        logic [31:0] rs_data, rt_data, imm;
        logic        alu_src, shamt_src, sign;
        logic [5:0]  fun;
    } ex_model_t;

    ex_model_t m;

    // Value a source register would really hold given the in-flight writers.
    function automatic logic [31:0] ref_value(input logic [4:0] r, input logic [31:0] raw);
        logic [31:0] v = raw;
        if (r != 0) begin
            if (mwb_wr_en && mwb_wr_addr == r) v = mwb_data;
            if (exm_wr_en && exm_wr_addr == r) v = exm_data;
        end
        return v;
    endfunction

    function automatic logic ref_hazard();
        return m.valid && m.is_load && m.wr_addr != 0 && id_valid &&
               (id_rs == m.wr_addr || id_rt == m.wr_addr);
    endfunction

    function automatic ex_model_t ref_next();
        ex_model_t n = m;
        ex_model_t ld;
        ld.valid = id_valid; ld.wr_en = id_wr_en; ld.is_load = id_is_load; ld.known = 1;
        ld.wr_addr = id_wr_addr; ld.rs = id_rs; ld.rt = id_rt; ld.shamt = id_shamt;
        ld.rs_data = id_rs_data; ld.rt_data = id_rt_data; ld.imm = id_imm;
        ld.alu_src = id_alu_src; ld.shamt_src = id_shamt_src; ld.sign = id_sign;
        ld.fun = id_alufun;
        if (!rst_n) begin
            n = '{default: '0};
            n.known = 1;
        end else if (flush || (!stall && ref_hazard())) begin
            n = ld;
            n.valid = 0; n.wr_en = 0; n.is_load = 0; n.known = 0;
        end else if (!stall) begin
            n = ld;
        end
        return n;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [4:0]  rs, rt, shamt;
        logic [31:0] rs_data, rt_data, imm;
        logic        alu_src, shamt_src;
        logic [5:0]  fun;
        logic        ee; logic [4:0] ea; logic [31:0] ed;
        logic        me; logic [4:0] ma; logic [31:0] md;
        logic [31:0] exp_a, exp_b, exp_store;
    } vec_t;

    vec_t vecs[8];

    initial begin
        ex_model_t nxt;
        logic exp_h;

        vecs[0] = '{5'd3, 5'd4, 5'd0, 32'h10, 32'h20, 32'h0, 1'b0, 1'b0, ALU_ADD,
                    1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h10, 32'h20, 32'h20};
        vecs[1] = '{5'd5, 5'd6, 5'd0, 32'h1, 32'h66, 32'h0, 1'b0, 1'b0, ALU_SUB,
                    1'b1, 5'd5, 32'hAAAA, 1'b1, 5'd5, 32'hBBBB, 32'hAAAA, 32'h66, 32'h66};
        vecs[2] = '{5'd5, 5'd6, 5'd0, 32'h1, 32'h66, 32'h0, 1'b0, 1'b0, ALU_OR,
                    1'b0, 5'd5, 32'hAAAA, 1'b1, 5'd5, 32'hBBBB, 32'hBBBB, 32'h66, 32'h66};
        vecs[3] = '{5'd0, 5'd1, 5'd0, 32'h1234, 32'h9, 32'h0, 1'b0, 1'b0, ALU_AND,
                    1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF, 32'h1234, 32'h9, 32'h9};
        vecs[4] = '{5'd0, 5'd2, 5'd4, 32'h0, 32'h1, 32'h0, 1'b0, 1'b1, ALU_SLL,
                    1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h4, 32'h1, 32'h1};
        vecs[5] = '{5'd1, 5'd9, 5'd0, 32'h7, 32'h3, 32'hFFFF_FFF0, 1'b1, 1'b0, ALU_LT,
                    1'b0, 5'd9, 32'h11, 1'b1, 5'd9, 32'h55, 32'h7, 32'hFFFF_FFF0, 32'h55};
        vecs[6] = '{5'd2, 5'd10, 5'd0, 32'h8, 32'h3, 32'h0, 1'b0, 1'b0, ALU_XOR,
                    1'b1, 5'd10, 32'hC0DE, 1'b1, 5'd10, 32'hF00D, 32'h8, 32'hC0DE, 32'hC0DE};
        vecs[7] = '{5'd11, 5'd12, 5'd0, 32'h5A, 32'hA5, 32'h0, 1'b0, 1'b0, ALU_NOR,
                    1'b1, 5'd12, 32'h1, 1'b0, 5'd11, 32'h2, 32'h5A, 32'h1, 32'h1};

        // Reset: random ID inputs while held in reset.
        drive_idle();
        rst_n = 0;
        @(negedge clk); drive_id_random();
        @(posedge clk); @(posedge clk); #1;
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_fun", 32'(alu_fun), 32'(ALU_ADD));
        chk("rst_ctrl", {28'b0, ex_valid, ex_wr_en, ex_is_load, alu_sign}, 0);
        chk("rst_store", ex_store_data, 0);
        chk("rst_hazard", 32'(hazard), 0);
        @(negedge clk); rst_n = 1; drive_idle();

        // Table-driven single-issue vectors.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive_idle();
            id_valid = 1; id_wr_en = 1; id_wr_addr = 5'(i + 16); id_sign = i[0];
            id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_shamt = vecs[i].shamt;
            id_rs_data = vecs[i].rs_data; id_rt_data = vecs[i].rt_data;
            id_imm = vecs[i].imm; id_alu_src = vecs[i].alu_src;
            id_shamt_src = vecs[i].shamt_src; id_alufun = vecs[i].fun;
            @(posedge clk); #1;
            drive_fwd(vecs[i].ee, vecs[i].ea, vecs[i].ed, vecs[i].me, vecs[i].ma, vecs[i].md);
            #1;
            chk($sformatf("vec%0d_alu_a", i), alu_a, vecs[i].exp_a);
            chk($sformatf("vec%0d_alu_b", i), alu_b, vecs[i].exp_b);
            chk($sformatf("vec%0d_store", i), ex_store_data, vecs[i].exp_store);
            chk($sformatf("vec%0d_fun", i), 32'(alu_fun), 32'(vecs[i].fun));
            chk($sformatf("vec%0d_sign", i), 32'(alu_sign), 32'(i[0]));
            chk($sformatf("vec%0d_valid", i), 32'(ex_valid), 1);
            chk($sformatf("vec%0d_wr_addr", i), 32'(ex_wr_addr), 32'(i + 16));
        end

        // Load-use: LW r7, then a consumer of r7.
        @(negedge clk); drive_idle();
        id_valid = 1; id_wr_en = 1; id_is_load = 1; id_wr_addr = 7;
        @(negedge clk); drive_idle();
        id_valid = 1; id_rs = 7; id_rt = 2; id_rs_data = 32'h0BAD; id_wr_en = 1; id_wr_addr = 8;
        #1;
        chk("lu_hazard_on", 32'(hazard), 1);
        @(posedge clk); #1;
        chk("lu_bubble_valid", 32'(ex_valid), 0);
        chk("lu_bubble_wr_en", 32'(ex_wr_en), 0);
        chk("lu_hazard_off", 32'(hazard), 0);
        @(posedge clk); #1;
        drive_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1EAD);
        #1;
        chk("lu_issue_valid", 32'(ex_valid), 1);
        chk("lu_issue_wr_addr", 32'(ex_wr_addr), 8);
        chk("lu_issue_alu_a", alu_a, 32'h1EAD);

        // Stall for 3 cycles with MEM/WB updating the registered rt.
        @(negedge clk); drive_idle();
        id_valid = 1; id_wr_en = 1; id_wr_addr = 3; id_rs = 0; id_rs_data = 32'h77;
        id_rt = 8; id_rt_data = 32'h1; id_alufun = ALU_SUB;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] d;
            @(negedge clk);
            stall = 1; id_wr_addr = 5'(20 + i); id_alufun = ALU_EQ; id_rs_data = $urandom;
            d = $urandom;
            drive_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, d);
            #1;
            chk($sformatf("stall%0d_alu_b", i), alu_b, d);
            @(posedge clk); #1;
            chk($sformatf("stall%0d_wr_addr", i), 32'(ex_wr_addr), 3);
            chk($sformatf("stall%0d_fun", i), 32'(alu_fun), 32'(ALU_SUB));
            chk($sformatf("stall%0d_alu_a", i), alu_a, 32'h77);
            chk($sformatf("stall%0d_valid", i), 32'(ex_valid), 1);
        end
        @(negedge clk); stall = 1; flush = 1;
        @(posedge clk); #1;
        chk("stflush_valid", 32'(ex_valid), 0);
        chk("stflush_wr_en", 32'(ex_wr_en), 0);

        // Reset asserted mid-stall clears on that edge.
        @(negedge clk); drive_idle();
        id_valid = 1; id_wr_en = 1; id_wr_addr = 9; id_alufun = ALU_SRA;
        @(negedge clk); stall = 1;
        @(negedge clk); rst_n = 0;
        @(posedge clk); #1;
        chk("rst_stall_valid", 32'(ex_valid), 0);
        chk("rst_stall_wr_addr", 32'(ex_wr_addr), 0);
        chk("rst_stall_fun", 32'(alu_fun), 0);
        @(negedge clk); drive_idle();
        @(posedge clk); #1;
        m = '{default: '0};
        m.known = 1;

        // Randomized traffic against the reference model.
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 31) != 0);
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            drive_id_random();
            drive_fwd(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                      1'($urandom), 5'($urandom_range(0, 7)), $urandom);
            #1;
            exp_h = ref_hazard();
            chk("rnd_hazard", 32'(hazard), 32'(exp_h));
            chk("rnd_ctrl", {29'b0, ex_valid, ex_wr_en, ex_is_load},
                {29'b0, m.valid, m.wr_en, m.is_load});
            if (m.known) begin
                exp_q.push_back(m.shamt_src ? {27'b0, m.shamt} : ref_value(m.rs, m.rs_data));
                exp_q.push_back(m.alu_src ? m.imm : ref_value(m.rt, m.rt_data));
                exp_q.push_back(ref_value(m.rt, m.rt_data));
                exp_q.push_back({20'b0, m.sign, m.fun, m.wr_addr});
                chk("rnd_alu_a", alu_a, exp_q.pop_front());
                chk("rnd_alu_b", alu_b, exp_q.pop_front());
                chk("rnd_store", ex_store_data, exp_q.pop_front());
                chk("rnd_fields", {20'b0, alu_sign, alu_fun, ex_wr_addr}, exp_q.pop_front());
            end
            nxt = ref_next();
            @(posedge clk);
            m = nxt;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", c_cnt, f_cnt);
        $finish;
    end

endmodule
